// File: rtl/sram_freeze_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM sequencer: FSM states and
// SRAM-side constants.
package sram_freeze_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int unsigned SRAM_DATA_W       = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 and flags the final count.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] count,
    output logic       terminal
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign terminal = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_freeze_controller.sv
// Splits each 32-bit MEM-stage access into two half-word accesses on a 16-bit
// asynchronous SRAM, holding ready low for the duration of the access.
module sram_freeze_controller
    import sram_freeze_controller_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    state_t                 state;
    state_t                 state_next;
    logic                   req;
    logic                   start;
    logic                   in_phase;
    logic                   op_write;
    logic [SRAM_DATA_W-1:0] data_hi_q;
    logic [ADDR_W-2:0]      word_in;
    logic [ADDR_W-2:0]      word_q;
    logic [3:0]             count;
    logic                   terminal;
    logic                   cnt_clear;
    logic                   cnt_en;

    assign req     = read_en | write_en;
    assign word_in = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        start      = 1'b0;
        cnt_en     = 1'b0;
        cnt_clear  = 1'b1;
        case (state)
            ST_IDLE: begin
                ready = ~req;
                if (req) begin
                    state_next = ST_LOW;
                    start      = 1'b1;
                end
            end
            ST_LOW: begin
                cnt_en    = 1'b1;
                cnt_clear = terminal;
                if (terminal) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                cnt_en    = 1'b1;
                cnt_clear = terminal;
                if (terminal) state_next = ST_DONE;
            end
            ST_DONE: begin
                ready      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write strobe releases on the final count so data is held past WE rising.
    always_comb begin
        in_phase   = (state == ST_LOW) || (state == ST_HIGH);
        sram_oe_n  = ~(in_phase & ~op_write);
        sram_dq_oe = in_phase & op_write;
        sram_we_n  = ~(in_phase & op_write & ~terminal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_write    <= 1'b0;
            data_hi_q   <= '0;
            word_q      <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            if (start) begin
                op_write  <= write_en;
                data_hi_q <= write_data[31:16];
                word_q    <= word_in;
                sram_addr <= {word_in, 1'b0};
                if (write_en) sram_dq_out <= write_data[15:0];
            end
            if ((state == ST_LOW) && terminal) begin
                sram_addr <= {word_q, 1'b1};
                if (op_write) sram_dq_out <= data_hi_q;
                else          read_data[15:0] <= sram_dq_in;
            end
            if ((state == ST_HIGH) && terminal && !op_write) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_freeze_controller.sv
// Directed bench: W=2 and W=4 instances, each against a small SRAM model that
// commits a write when WE rises while the pad is still driven.
module tb_sram_freeze_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;

    logic [31:0] read_data,   read_data4;
    logic        ready,       ready4;
    logic [17:0] sram_addr,   sram_addr4;
    logic [15:0] sram_dq_out, sram_dq_out4;
    logic [15:0] sram_dq_in,  sram_dq_in4;
    logic        sram_dq_oe,  sram_dq_oe4;
    logic        sram_we_n,   sram_we_n4;
    logic        sram_oe_n,   sram_oe_n4;

    logic [15:0] mem  [16];
    logic [15:0] mem4 [16];
    logic        we_prev  = 1'b1;
    logic        we_prev4 = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_freeze_controller #(
        .ADDR_W (18), .WAIT_CYCLES (2), .BASE_ADDR (32'd1024)
    ) dut (
        .clk (clk), .rst (rst), .read_en (read_en), .write_en (write_en),
        .address (address), .write_data (write_data), .read_data (read_data),
        .ready (ready), .sram_addr (sram_addr), .sram_dq_out (sram_dq_out),
        .sram_dq_in (sram_dq_in), .sram_dq_oe (sram_dq_oe),
        .sram_we_n (sram_we_n), .sram_oe_n (sram_oe_n)
    );

    sram_freeze_controller #(
        .ADDR_W (18), .WAIT_CYCLES (4), .BASE_ADDR (32'd1024)
    ) dut4 (
        .clk (clk), .rst (rst), .read_en (read_en), .write_en (write_en),
        .address (address), .write_data (write_data), .read_data (read_data4),
        .ready (ready4), .sram_addr (sram_addr4), .sram_dq_out (sram_dq_out4),
        .sram_dq_in (sram_dq_in4), .sram_dq_oe (sram_dq_oe4),
        .sram_we_n (sram_we_n4), .sram_oe_n (sram_oe_n4)
    );

    assign sram_dq_in  = mem[sram_addr[3:0]];
    assign sram_dq_in4 = mem4[sram_addr4[3:0]];

    always @(negedge clk) begin
        if (!we_prev && sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] = sram_dq_out;
        we_prev = sram_we_n;
        if (!we_prev4 && sram_we_n4 && sram_dq_oe4) mem4[sram_addr4[3:0]] = sram_dq_out4;
        we_prev4 = sram_we_n4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 16'h0000;
            mem4[i] = 16'h0000;
        end
        mem[4]   = 16'h1234;
        mem[5]   = 16'hABCD;
        mem[13]  = 16'h5555;
        mem4[4]  = 16'h8765;
        mem4[5]  = 16'h4321;

        rst = 1'b1; read_en = 1'b0; write_en = 1'b0;
        address = '0; write_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        @(negedge clk); #1;
        check("rst_ready",   ready,      1);
        check("rst_we_n",    sram_we_n,  1);
        check("rst_oe_n",    sram_oe_n,  1);
        check("rst_dq_oe",   sram_dq_oe, 0);
        check("rst_rdata",   read_data,  0);
        check("rst_addr",    sram_addr,  0);
        check("rst_rdata4",  read_data4, 0);

        // Write 0xDEADBEEF to 1024
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            write_en = (k < 5); address = 32'd1024; write_data = 32'hDEADBEEF;
            #1;
            check($sformatf("wr_ready%0d", k), ready, (k == 5));
            if (k >= 1 && k <= 4) begin
                check($sformatf("wr_addr%0d", k),  sram_addr,   (k <= 2) ? 0 : 1);
                check($sformatf("wr_dq%0d", k),    sram_dq_out, (k <= 2) ? 32'hBEEF : 32'hDEAD);
                check($sformatf("wr_we_n%0d", k),  sram_we_n,   (k == 1 || k == 3) ? 0 : 1);
                check($sformatf("wr_dq_oe%0d", k), sram_dq_oe,  1);
                check($sformatf("wr_oe_n%0d", k),  sram_oe_n,   1);
            end
        end
        check("wr_mem0", mem[0], 32'hBEEF);
        check("wr_mem1", mem[1], 32'hDEAD);
        check("wr_rdata_kept", read_data, 0);

        // Read from 1032 (half-words 4,5)
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            write_en = 1'b0; read_en = (k < 5); address = 32'd1032;
            #1;
            check($sformatf("rd_ready%0d", k), ready, (k == 5));
            if (k >= 1 && k <= 4) begin
                check($sformatf("rd_addr%0d", k),  sram_addr,  (k <= 2) ? 4 : 5);
                check($sformatf("rd_oe_n%0d", k),  sram_oe_n,  0);
                check($sformatf("rd_dq_oe%0d", k), sram_dq_oe, 0);
                check($sformatf("rd_we_n%0d", k),  sram_we_n,  1);
            end
        end
        check("rd_data", read_data, 32'hABCD1234);
        check("rd_oe_n_done", sram_oe_n, 1);

        // Both enables held for two accesses; address changes after the first latch
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            read_en  = (k < 11);
            write_en = (k < 11);
            address    = (k == 0) ? 32'd1040 : 32'd1044;
            write_data = (k == 0) ? 32'h11112222 : 32'h33334444;
            #1;
            check($sformatf("b2b_ready%0d", k), ready, (k == 5 || k == 11));
            if (k == 1) check("b2b_addr_first",  sram_addr, 8);
            if (k == 7) check("b2b_addr_second", sram_addr, 10);
            if (k == 7) check("b2b_dq_oe",       sram_dq_oe, 1);
        end
        check("b2b_mem8",  mem[8],  32'h2222);
        check("b2b_mem9",  mem[9],  32'h1111);
        check("b2b_mem10", mem[10], 32'h4444);
        check("b2b_mem11", mem[11], 32'h3333);
        check("b2b_rdata_kept", read_data, 32'hABCD1234);

        // Reset during HIGH of a write to 1048 (half-words 12,13)
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            read_en = 1'b0; write_en = (k < 3); address = 32'd1048;
            write_data = 32'hCAFEF00D;
            rst = (k == 3);
            #1;
            if (k == 3) check("rstmid_in_high_we_n", sram_we_n, 0);
        end
        @(negedge clk);
        rst = 1'b0; write_en = 1'b0;
        #1;
        check("rstmid_ready", ready,      1);
        check("rstmid_we_n",  sram_we_n,  1);
        check("rstmid_dq_oe", sram_dq_oe, 0);
        check("rstmid_rdata", read_data,  0);
        check("rstmid_addr",  sram_addr,  0);
        check("rstmid_mem12", mem[12], 32'hF00D);
        check("rstmid_mem13", mem[13], 32'h5555);
        check("rstmid_rdata4", read_data4, 0);

        // WAIT_CYCLES=4 read from 1032
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            read_en = (k < 9); write_en = 1'b0; address = 32'd1032;
            #1;
            check($sformatf("w4_ready%0d", k), ready4, (k == 9));
            if (k == 4) check("w4_rdata_before_lo", read_data4, 0);
            if (k == 5) check("w4_rdata_lo",        read_data4, 32'h00008765);
            if (k == 5) check("w4_addr_hi",         sram_addr4, 5);
            if (k == 8) check("w4_rdata_before_hi", read_data4, 32'h00008765);
            if (k == 9) check("w4_rdata",           read_data4, 32'h43218765);
        end
        read_en = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_freeze_controller.md
Name: sram_freeze_controller

Overview:
Sequences every MEM-stage data access of the pipelined ARM core onto an external 16-bit asynchronous SRAM. Each 32-bit access is split into two half-word accesses, each lasting WAIT_CYCLES. While an access is in flight, the block holds ready low. The top level drives the pipeline freeze inputs with the inverse of ready. The block sits between the MEM stage request signals and the SRAM pins; the tri-state pad logic lives in the top level.

Parameters:
ADDR_W, 18, SRAM half-word address width.
WAIT_CYCLES, 2, cycles per half-word access; legal range 2..15.
BASE_ADDR, 1024, CPU byte address that maps to SRAM half-word 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
read_en  in  1  MEM-stage load request, held by the pipeline while frozen
write_en  in  1  MEM-stage store request, held by the pipeline while frozen
address  in  32  CPU byte address (ALU result)
write_data  in  32  store data (reg2)
read_data  out  32  load result, registered
ready  out  1  1 = access complete or no access; 0 = freeze the pipeline
sram_addr  out  ADDR_W  SRAM half-word address
sram_dq_out  out  16  write data to the pad
sram_dq_in  in  16  read data from the pad
sram_dq_oe  out  1  1 = drive the pad
sram_we_n  out  1  active-low write strobe
sram_oe_n  out  1  active-low output enable

Behaviour:
- Address mapping: word = (address - BASE_ADDR) >> 2. The low half uses address {word,0} and the high half uses {word,1}, both truncated to ADDR_W. Bits [1:0] of address are ignored.
- req = read_en | write_en. If both are high, the access is treated as a write.
- States:
  - IDLE: if req, go to LOW.
  - LOW: after WAIT_CYCLES cycles, go to HIGH.
  - HIGH: after WAIT_CYCLES cycles, go to DONE.
  - DONE: go to IDLE unconditionally. The still-asserted old request is not re-sampled.
- On the IDLE->LOW edge: latch address, write_data and the op (read or write). Held inputs are ignored after that point.
- Wait counter: cleared on entry to LOW and to HIGH; counts 0..WAIT_CYCLES-1; the phase ends at WAIT_CYCLES-1.
- ready (combinational):
  - ready = (IDLE & ~req) | DONE.
  - Low from the request cycle through the end of HIGH.
  - Total freeze is 2*WAIT_CYCLES+1 cycles; for W=2, ready is low at cycles 0-4 and high at cycle 5.
- Read phases:
  - sram_oe_n = 0 in LOW and HIGH; sram_dq_oe = 0.
  - At the final count of LOW, sram_dq_in is captured into read_data[15:0].
  - At the final count of HIGH, sram_dq_in is captured into read_data[31:16].
  - read_data is valid in DONE and holds until the next read overwrites it. Writes never change read_data.
- Write phases:
  - sram_dq_oe = 1 throughout LOW and HIGH.
  - sram_dq_out = latched data[15:0] in LOW and [31:16] in HIGH.
  - sram_we_n = 0 for counts 0..WAIT_CYCLES-2 and 1 on the final count, giving data hold time.
- Outside LOW and HIGH: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0. sram_addr and sram_dq_out hold their last values.
- Back-to-back accesses: with req still high after DONE->IDLE, the new access starts immediately. Requests are separated by one ready-high cycle (DONE).
- Reset: values at reset, including mid-access (the access is aborted, no completion reported):
  - state IDLE, counter 0
  - read_data 0, sram_addr 0, sram_dq_out 0
  - sram_we_n 1, sram_oe_n 1, sram_dq_oe 0
  - ready follows the IDLE rule.
- All registers update on the rising clk edge only.

Decomposition:
- Shared package: state encodings (IDLE, LOW, HIGH, DONE), the BASE_ADDR default, and the SRAM data width constant 16.
- Sub-module sram_wait_counter: 4-bit, with clear, enable and a terminal flag at WAIT_CYCLES-1.
- The FSM, latches and strobe decode stay in sram_freeze_controller.

Test Plan:
- Reset then idle, no request -> ready=1, we_n=1, oe_n=1, dq_oe=0, read_data=0.
- Write 0xDEADBEEF to address 1024, W=2:
  - ready low for 5 cycles;
  - sram_addr 0 then 1;
  - dq_out 0xBEEF then 0xDEAD;
  - we_n low exactly 1 cycle per phase.
- Read from address 1032 with the SRAM model returning 0x1234 at half-word 4 and 0xABCD at half-word 5 -> read_data=0xABCD1234 in DONE with ready=1; 5 freeze cycles.
- read_en and write_en held for two consecutive accesses -> ready pattern 0,0,0,0,0,1,0,0,0,0,0,1; the second access uses the new address.
- rst asserted during HIGH of a write -> next cycle IDLE, we_n=1, dq_oe=0, read_data=0; the SRAM high half is not written.
- WAIT_CYCLES=4 read -> ready low for 9 cycles; data captured on the 4th cycle of each phase.
